// File: rtl/npc_sequencer.sv
// Next-PC sequencer: picks the address the PC register loads next, and owns delay-slot, EPC/BD and ERET state.
// Latency: npc, link_addr and addr_err are combinational (zero cycles); epc, bd and in_delay are registered.
// Backpressure: stall holds all internal state and drives npc=pc so the PC register reloads itself.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   pc                     current PC register value
//   npc_op                 0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 ERET (6-7 behave as SEQ)
//   br_take, imm16         branch condition and word offset
//   instr_index            26-bit jump index
//   rs_val                 JR target register value
//   exc_req                exception request for the instruction at pc
//   stall                  freeze state, npc = pc
//   npc                    next PC
//   link_addr              JAL return address
//   epc, bd                captured exception PC and branch-delay flag
//   in_delay               current pc is a delay-slot instruction
//   addr_err               misaligned JR target (raises an exception)
module npc_sequencer #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic        br_take,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  input  logic        exc_req,
  input  logic        stall,
  output logic [31:0] npc,
  output logic [31:0] link_addr,
  output logic [31:0] epc,
  output logic        bd,
  output logic        in_delay,
  output logic        addr_err
);

  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JAL  = 3'd3;
  localparam logic [2:0] OP_JR   = 3'd4;
  localparam logic [2:0] OP_ERET = 3'd5;

  typedef enum logic {
    NORMAL = 1'b0,
    DELAY  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic [31:0] epc_nxt;
  logic        bd_nxt;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        is_br, is_j, is_jal, is_jr, is_eret;
  logic        taken;
  logic        exc;

  assign pc4     = pc + 32'd4;
  assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};

  assign is_br   = (npc_op == OP_BR);
  assign is_j    = (npc_op == OP_J);
  assign is_jal  = (npc_op == OP_JAL);
  assign is_jr   = (npc_op == OP_JR);
  assign is_eret = (npc_op == OP_ERET);

  assign taken   = is_j | is_jal | is_jr | (is_br & br_take);

  always_comb begin
    target = pc4 + br_off;
    if (is_j | is_jal) begin
      target = {pc4[31:28], instr_index, 2'b00};
    end else if (is_jr) begin
      target = rs_val;
    end
  end

  // The jump in a delay slot is ignored, so its alignment cannot fault.
  assign addr_err  = (state == NORMAL) && is_jr && (rs_val[1:0] != 2'b00);
  assign exc       = exc_req | addr_err;
  assign in_delay  = (state == DELAY);
  assign link_addr = pc + (DELAY_SLOT ? 32'd8 : 32'd4);

  always_comb begin
    npc = pc4;
    if (reset) begin
      npc = RESET_VEC;
    end else if (stall) begin
      npc = pc;
    end else if (exc) begin
      npc = EXC_VEC;
    end else if ((state == NORMAL) && is_eret) begin
      npc = epc;
    end else if (state == DELAY) begin
      npc = pend_tgt;
    end else if (taken && !DELAY_SLOT) begin
      npc = target;
    end
  end

  always_comb begin
    state_nxt    = state;
    pend_tgt_nxt = pend_tgt;
    epc_nxt      = epc;
    bd_nxt       = bd;
    if (!stall) begin
      if (exc) begin
        // In a delay slot the restart point is the branch, one word back.
        epc_nxt      = (state == DELAY) ? (pc - 32'd4) : pc;
        bd_nxt       = (state == DELAY);
        state_nxt    = NORMAL;
        pend_tgt_nxt = '0;
      end else if (state == DELAY) begin
        state_nxt = NORMAL;
      end else if (taken && DELAY_SLOT) begin
        pend_tgt_nxt = target;
        state_nxt    = DELAY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NORMAL;
      pend_tgt <= '0;
      epc      <= '0;
      bd       <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_tgt <= pend_tgt_nxt;
      epc      <= epc_nxt;
      bd       <= bd_nxt;
    end
  end

endmodule

// File: doc/npc_sequencer.md
Name: npc_sequencer

Overview:
- Next-PC sequencer for the single-issue MIPS datapath.
- Consumes the current `pc` from the program-counter register and the decoded control-transfer request.
- Produces the `npc` that the program-counter register loads on the next clock edge.
- Owns the branch-delay-slot state, the exception redirect, EPC capture and ERET return. This is the sequential counterpart that drives the PC's `npc` input.

Parameters:
- RESET_VEC, 32'h0000_3000, address driven on npc while reset is high; matches PC reset value
- EXC_VEC, 32'h0000_4180, exception handler entry address
- DELAY_SLOT, 1, 1 = MIPS delayed branches/jumps; 0 = immediate redirect

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pc  in  32  current PC register value
- npc_op  in  3  0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 ERET; 6-7 treated as SEQ
- br_take  in  1  branch condition result from comparator, used only with BR
- imm16  in  16  branch offset field
- instr_index  in  26  jump index field
- rs_val  in  32  register value for JR
- exc_req  in  1  external exception request for the instruction at pc
- stall  in  1  hold current pc and internal state
- npc  out  32  next PC
- link_addr  out  32  return address for JAL
- epc  out  32  saved exception PC
- bd  out  1  exception was taken in a delay slot
- in_delay  out  1  current pc is a delay-slot instruction
- addr_err  out  1  JR target misaligned (combinational)

Behaviour:
- Reset (async): state=NORMAL, pend_tgt=0, epc=0, bd=0, in_delay=0.
  - While reset is high, npc=RESET_VEC.
  - Reset mid-delay discards the pending target.
- Target arithmetic, all 32-bit with wrap-around modulo 2^32:
  - pc4 = pc+4.
  - BR target = pc4 + (sign_ext(imm16)<<2).
  - J/JAL target = {pc4[31:28], instr_index, 2'b00}.
  - JR target = rs_val.
- link_addr = DELAY_SLOT ? pc+8 : pc+4. Combinational at all times.
- Taken transfer: J, JAL, JR, or BR with br_take=1.
- addr_err = (npc_op==JR) && rs_val[1:0]!=0, evaluated in NORMAL state only; it acts as an exception.
- Exception = exc_req | addr_err.
- States: NORMAL, DELAY. in_delay = (state==DELAY).
- npc selection, priority high to low:
  1. reset: RESET_VEC.
  2. stall: pc (PC reloads itself).
  3. exception: EXC_VEC.
  4. ERET (NORMAL only): epc. No delay slot.
  5. DELAY state: pend_tgt.
  6. Taken transfer in NORMAL: target if DELAY_SLOT=0, else pc4.
  7. Otherwise: pc4.
- Clock edge with stall=1: no state, pend_tgt, epc or bd change.
- Clock edge with stall=0:
  - Exception in NORMAL: epc<=pc, bd<=0, state<=NORMAL.
  - Exception in DELAY: epc<=pc-4 (address of the branch), bd<=1, state<=NORMAL, pend_tgt discarded.
  - Taken transfer in NORMAL with DELAY_SLOT=1: pend_tgt<=target, state<=DELAY.
  - DELAY with no exception: state<=NORMAL.
    - Any npc_op in the delay slot (including ERET or a taken transfer) is ignored.
    - npc=pend_tgt.
  - ERET in NORMAL: state stays NORMAL; epc and bd unchanged.
- Simultaneous exc_req and taken transfer: exception wins; no pending target is recorded.
- Simultaneous stall and exc_req: stall wins. The exception is re-evaluated on the next unstalled cycle; the requester holds exc_req.
- DELAY_SLOT=0: the state machine never leaves NORMAL; bd is always 0.
- Timing: all outputs except epc, bd and in_delay are combinational from inputs plus state. Zero-cycle latency to npc. A redirect takes effect one instruction later when DELAY_SLOT=1.

Test Plan:
- Reset, then release with pc=0x3000, npc_op=SEQ:
  - npc=0x3000 during reset; 0x3004 after release.
  - epc=0, in_delay=0.
- BR with br_take=1, pc=0x3008, imm16=0xFFFE:
  - npc=0x300C, then next cycle (pc=0x300C) in_delay=1, npc=0x3004 (wraps backward correctly).
  - Repeat with br_take=0: npc stays 0x300C with no DELAY.
- JAL at pc=0x3010, instr_index=0x0000C40:
  - link_addr=0x3018, npc=0x3014.
  - Next cycle npc=0x0000_3100.
- exc_req asserted in DELAY at pc=0x3014:
  - npc=0x4180, epc=0x3010, bd=1, state NORMAL.
  - Then ERET at pc=0x4200: npc=0x3010.
- JR with rs_val=0x3002 at pc=0x3020:
  - addr_err=1, npc=0x4180, epc=0x3020.
- stall=1 held 3 cycles during DELAY:
  - npc=pc each cycle, in_delay stays 1, pend_tgt unchanged.
  - Release: npc=pend_tgt.
- Assert reset mid-DELAY: in_delay=0 and npc=0x3000 immediately, asynchronously.
